// File: rtl/bird_motion.sv
// ---------------------------------------------------------------------------
// bird_motion
//   Vertical motion engine for the flappy-bird sprite. Once per video frame
//   it applies gravity, flaps, ceiling and floor clamps, and tracks the game
//   state (READY / FLY / FALLEN).
//
// Ports
//   Clk         in   system clock, the only clock
//   Reset       in   synchronous active-high reset
//   frame_vs    in   raw VGA vsync (active low), asynchronous to Clk
//   keycode     in   two HID usage codes, [7:0] and [15:8]
//   BirdX       out  bird centre X (constant)
//   BirdY       out  bird centre Y
//   BirdS       out  bird half-size (constant)
//   Velocity    out  signed vertical velocity, pixels/frame, positive = down
//   game_state  out  00 READY, 01 FLY, 10 FALLEN
//   frame_tick  out  one-Clk pulse per frame (end of vsync pulse)
// ---------------------------------------------------------------------------
module bird_motion #(
  parameter logic [7:0] FLAP_KEY  = 8'h2C,
  parameter logic [9:0] BIRD_X0   = 10'd160,
  parameter logic [9:0] BIRD_Y0   = 10'd240,
  parameter logic [9:0] BIRD_SIZE = 10'd8,
  parameter int         GRAVITY   = 1,
  parameter int         FLAP_VEL  = -8,
  parameter int         VMAX      = 10,
  parameter logic [9:0] Y_MAX     = 10'd479
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_vs,
  input  logic [15:0] keycode,
  output logic [9:0]  BirdX,
  output logic [9:0]  BirdY,
  output logic [9:0]  BirdS,
  output logic [5:0]  Velocity,
  output logic [1:0]  game_state,
  output logic        frame_tick
);

  typedef enum logic [1:0] {
    ST_READY  = 2'b00,
    ST_FLY    = 2'b01,
    ST_FALLEN = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  localparam logic signed [10:0] C_GRAVITY  = 11'(GRAVITY);
  localparam logic signed [10:0] C_FLAP_VEL = 11'(FLAP_VEL);
  localparam logic signed [10:0] C_VMAX     = 11'(VMAX);
  localparam logic [9:0]         C_Y_FLOOR  = Y_MAX - BIRD_SIZE;
  localparam logic signed [10:0] C_TOP_S    = $signed({1'b0, BIRD_SIZE});
  localparam logic signed [10:0] C_FLOOR_S  = $signed({1'b0, C_Y_FLOOR});

  // frame sync / tick
  logic r_vs_meta;
  logic r_vs_sync;
  logic r_vs_prev;
  logic r_tick;

  // flap key tracking
  logic [1:0] w_key_hit;
  logic       w_key_any;
  logic       r_key_down;
  logic       r_key_prev;
  logic       r_flap_pend;
  logic       w_press;
  logic       w_consume;

  // motion state
  state_t     r_state;
  state_t     w_state_next;
  logic [9:0] r_bird_y;
  logic [9:0] w_bird_y_next;
  logic [5:0] r_vel;
  logic [5:0] w_vel_next;

  // FLY update datapath (11-bit signed so negative y and overflow are visible)
  logic signed [10:0] w_vel_ext;
  logic signed [10:0] w_vel_grav;
  logic signed [10:0] w_vel_fall;
  logic signed [10:0] w_vel_new;
  logic signed [10:0] w_y_new;
  state_t             w_fly_state;
  logic [9:0]         w_fly_y;
  logic [5:0]         w_fly_vel;
  logic               w_unused_bits;

  // -------------------------------------------------------------------------
  // vsync synchronizer. Flops reset high so a reset released while vsync is
  // idle (high) never produces a spurious tick. The tick is registered, which
  // puts it 3 Clk after the raw rising edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vs_meta <= 1'b1;
      r_vs_sync <= 1'b1;
      r_vs_prev <= 1'b1;
      r_tick    <= 1'b0;
    end else begin
      r_vs_meta <= frame_vs;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
      r_tick    <= r_vs_sync & ~r_vs_prev;
    end
  end

  // -------------------------------------------------------------------------
  // flap key: either keycode slot may carry the flap usage code
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key_slot
      assign w_key_hit[gi] = (keycode[gi*8 +: 8] == FLAP_KEY);
    end
  endgenerate

  assign w_key_any = |w_key_hit;
  assign w_press   = r_key_down & ~r_key_prev;
  // every legal state consumes a pending flap on a tick
  assign w_consume = r_tick & r_flap_pend & (r_state != ST_BAD);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_key_down  <= 1'b0;
      r_key_prev  <= 1'b0;
      r_flap_pend <= 1'b0;
    end else begin
      r_key_down <= w_key_any;
      r_key_prev <= r_key_down;
      // a new press wins over consumption so a press landing on the
      // consuming tick is kept for the following frame
      if (w_press) begin
        r_flap_pend <= 1'b1;
      end else if (w_consume) begin
        r_flap_pend <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FLY update: new velocity, new position, then ceiling/floor clamp
  // -------------------------------------------------------------------------
  assign w_vel_ext  = {{5{r_vel[5]}}, r_vel};
  assign w_vel_grav = w_vel_ext + C_GRAVITY;
  assign w_vel_fall = (w_vel_grav > C_VMAX) ? C_VMAX : w_vel_grav;
  assign w_vel_new  = r_flap_pend ? C_FLAP_VEL : w_vel_fall;
  assign w_y_new    = $signed({1'b0, r_bird_y}) + w_vel_new;

  // upper bits are only needed for the signed range compares
  assign w_unused_bits = ^{w_vel_new[10:6], w_y_new[10]};

  always_comb begin
    w_fly_state = ST_FLY;
    w_fly_y     = w_y_new[9:0];
    w_fly_vel   = w_vel_new[5:0];
    if (w_y_new < C_TOP_S) begin
      w_fly_y   = BIRD_SIZE;
      w_fly_vel = '0;
    end else if (w_y_new > C_FLOOR_S) begin
      w_fly_y     = C_Y_FLOOR;
      w_fly_vel   = '0;
      w_fly_state = ST_FALLEN;
    end
  end

  // -------------------------------------------------------------------------
  // game FSM: next-state and position/velocity
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_bird_y_next = r_bird_y;
    w_vel_next    = r_vel;
    case (r_state)
      ST_READY: begin
        w_bird_y_next = BIRD_Y0;
        w_vel_next    = '0;
        // the launching flap is applied in the same tick
        if (r_tick && r_flap_pend) begin
          w_state_next  = w_fly_state;
          w_bird_y_next = w_fly_y;
          w_vel_next    = w_fly_vel;
        end
      end
      ST_FLY: begin
        if (r_tick) begin
          w_state_next  = w_fly_state;
          w_bird_y_next = w_fly_y;
          w_vel_next    = w_fly_vel;
        end
      end
      ST_FALLEN: begin
        if (r_tick && r_flap_pend) begin
          w_state_next  = ST_READY;
          w_bird_y_next = BIRD_Y0;
          w_vel_next    = '0;
        end
      end
      default: begin
        // illegal encoding: recover immediately, no tick needed
        w_state_next  = ST_READY;
        w_bird_y_next = BIRD_Y0;
        w_vel_next    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= ST_READY;
      r_bird_y <= BIRD_Y0;
      r_vel    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_bird_y <= w_bird_y_next;
      r_vel    <= w_vel_next;
    end
  end

  assign BirdX      = BIRD_X0;
  assign BirdS      = BIRD_SIZE;
  assign BirdY      = r_bird_y;
  assign Velocity   = r_vel;
  assign game_state = r_state;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_bird_motion.sv
// ---------------------------------------------------------------------------
// tb_bird_motion
//   Self-checking bench for bird_motion. Directed frame sequences followed by
//   randomized frames, all compared against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_bird_motion;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_vs;
  logic [15:0] keycode;
  logic [9:0]  BirdX;
  logic [9:0]  BirdY;
  logic [9:0]  BirdS;
  logic [5:0]  Velocity;
  logic [1:0]  game_state;
  logic        frame_tick;

  bird_motion dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_vs   (frame_vs),
    .keycode    (keycode),
    .BirdX      (BirdX),
    .BirdY      (BirdY),
    .BirdS      (BirdS),
    .Velocity   (Velocity),
    .game_state (game_state),
    .frame_tick (frame_tick)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int frame_no = 0;

  // reference model: game state, Y, velocity, pending flap, key level
  int m_st;
  int m_y;
  int m_v;
  bit m_pend;
  bit m_prev_hit;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d (frame %0d)", tag, obs, exp, frame_no);
    end
  endtask

  function automatic bit is_flap(input logic [15:0] kc);
    return (kc[7:0] == 8'h2C) || (kc[15:8] == 8'h2C);
  endfunction

  function automatic int vel_int();
    return int'($signed(Velocity));
  endfunction

  // One frame of game rules in plain arithmetic.
  task automatic model_fly();
    int vn;
    int yn;
    if (m_pend) vn = -8;
    else        vn = (m_v + 1 > 10) ? 10 : m_v + 1;
    m_pend = 0;
    yn = m_y + vn;
    if (yn < 8) begin
      m_y = 8;   m_v = 0;
    end else if (yn > 471) begin
      m_y = 471; m_v = 0; m_st = 2;
    end else begin
      m_y = yn;  m_v = vn;
    end
  endtask

  task automatic model_tick();
    case (m_st)
      0: if (m_pend) begin m_st = 1; model_fly(); end
      1: model_fly();
      2: if (m_pend) begin m_st = 0; m_y = 240; m_v = 0; m_pend = 0; end
      default: ;
    endcase
  endtask

  task automatic set_key(input logic [15:0] kc);
    @(negedge Clk);
    keycode = kc;
    if (is_flap(kc) && !m_prev_hit) m_pend = 1;
    m_prev_hit = is_flap(kc);
    repeat (4) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset    = 1'b1;
    keycode  = 16'h0000;
    frame_vs = 1'b1;
    @(posedge Clk);
    #1;
    check_val("rst_state", int'(game_state), 0);
    check_val("rst_y", int'(BirdY), 240);
    check_val("rst_v", vel_int(), 0);
    check_val("rst_tick", int'(frame_tick), 0);
    check_val("rst_x", int'(BirdX), 160);
    check_val("rst_s", int'(BirdS), 8);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    m_st = 0; m_y = 240; m_v = 0; m_pend = 0; m_prev_hit = 0;
    $display("reset   st=%0d y=%0d v=%0d", game_state, BirdY, vel_int());
  endtask

  // Present a key, run one vsync pulse, check tick shape and the update.
  // late: press the flap key so its edge lands on the tick cycle itself.
  task automatic do_frame(input logic [15:0] kc, input bit repress, input bit late);
    int n_hi;
    int first;
    if (repress) set_key(16'h0000);
    set_key(kc);
    @(negedge Clk);
    frame_vs = 1'b0;
    repeat (3) @(negedge Clk);
    frame_vs = 1'b1;
    n_hi  = 0;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk);
      if (frame_tick) begin
        n_hi++;
        if (first == 0) first = i;
      end
      if (i == 2 && late) keycode = 16'h002C;
      if (i == 3) begin
        check_val("hold_y", int'(BirdY), m_y);
        check_val("hold_st", int'(game_state), m_st);
      end
    end
    frame_no++;
    check_val("tick_width", n_hi, 1);
    check_val("tick_latency", first, 3);
    model_tick();
    if (late) begin
      if (!m_prev_hit) m_pend = 1;
      m_prev_hit = 1;
    end
    check_val("state", int'(game_state), m_st);
    check_val("bird_y", int'(BirdY), m_y);
    check_val("velocity", vel_int(), m_v);
    $display("frame %0d key=%04h st=%0d y=%0d v=%0d", frame_no, kc, game_state, BirdY, vel_int());
  endtask

  initial begin
    logic [15:0] kc;
    int          r;
    Reset    = 1'b1;
    frame_vs = 1'b1;
    keycode  = 16'h0000;
    do_reset();

    // idle frames stay READY
    for (int i = 0; i < 3; i++) do_frame(16'h0000, 0, 0);
    check_val("idle_state", int'(game_state), 0);
    check_val("idle_y", int'(BirdY), 240);

    // first flap, then gravity
    do_frame(16'h002C, 0, 0);
    check_val("flap1_v", vel_int(), -8);
    check_val("flap1_y", int'(BirdY), 232);
    do_frame(16'h0000, 0, 0);
    check_val("grav_v", vel_int(), -7);
    check_val("grav_y", int'(BirdY), 225);

    // holding the key yields a single flap
    do_reset();
    do_frame(16'h002C, 0, 0);
    for (int i = 0; i < 4; i++) do_frame(16'h2C00, 0, 0);
    check_val("hold_key_v", vel_int(), -4);

    // free fall to the floor, then hold
    for (int i = 0; i < 80 && m_st != 2; i++) do_frame(16'h0000, 0, 0);
    do_frame(16'h0000, 0, 0);
    do_frame(16'h0000, 0, 0);
    check_val("floor_state", int'(game_state), 2);
    check_val("floor_y", int'(BirdY), 471);
    check_val("floor_v", vel_int(), 0);

    // FALLEN -> READY on flap
    do_frame(16'h002C, 0, 0);
    check_val("restart_state", int'(game_state), 0);
    check_val("restart_y", int'(BirdY), 240);

    // flap every frame up to the ceiling
    for (int i = 0; i < 40 && !(m_y == 8 && m_st == 1); i++) do_frame(16'h002C, 1, 0);
    do_frame(16'h002C, 1, 0);
    check_val("ceil_state", int'(game_state), 1);
    check_val("ceil_y", int'(BirdY), 8);
    check_val("ceil_v", vel_int(), 0);

    // reset mid-flight, and a pending flap does not survive reset
    do_reset();
    set_key(16'h002C);
    do_reset();
    do_frame(16'h0000, 0, 0);
    check_val("no_carry_state", int'(game_state), 0);

    // press edge coincident with the consuming tick is kept
    do_frame(16'h002C, 0, 0);
    do_frame(16'h0000, 0, 1);
    do_frame(16'h0000, 0, 0);
    check_val("late_press_v", vel_int(), -8);
    check_val("late_press_y", int'(BirdY), 217);

    // randomized frames
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0:       kc = {8'($urandom), 8'($urandom)};
        1:       kc = {8'($urandom), 8'h2C};
        2:       kc = {8'h2C, 8'($urandom)};
        default: kc = 16'h0000;
      endcase
      if ($urandom_range(0, 39) == 0) do_reset();
      do_frame(kc, 1'($urandom_range(0, 1)),
               !is_flap(kc) && ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
